regfile_sb: RTL and testbench



---
 rtl/regfile_sb.sv | 163 ++++++++++++++++
 tb/tb_regfile_sb.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
//
// Purpose:
//    Parametrised register file with NRD combinational read ports, one
//    writeback port with same-cycle write-to-read bypass, and a per-register
//    pending-write scoreboard.  The RF stage marks a destination pending on
//    issue and stalls any operand whose pending bit is set.  The WB stage
//    clears it on writeback.  A pipeline flush clears every pending bit.
//
// Configuration macro:
//    REGFILE_SB_ZERO_REG_EN - when defined, register 0 is hard-wired to zero.
//                             Writes to it are ignored, bypass is suppressed
//                             for address 0, and issue to it is ignored.
//                             When undefined, register 0 is ordinary.
//
// Parameters:
//    DW    data width in bits
//    NREG  number of registers (power of two, >= 2)
//    NRD   number of read ports (>= 1)
//    AW    register address width (derived)
//    CW    width of the pending-register count (derived)
//
// Ports:
//    clk       rising-edge clock
//    rst       asynchronous active-low reset
//    rd_addr   read addresses, port i at [i*AW +: AW]
//    rd_data   read data, port i at [i*DW +: DW] (combinational)
//    rd_busy   per-port operand-pending flag (stall request)
//    wr_en     writeback strobe
//    wr_addr   writeback register
//    wr_data   writeback data
//    iss_en    mark iss_addr pending
//    iss_addr  destination register being issued
//    flush     clear all pending bits
//    busy      registered scoreboard vector
//    n_busy    registered population count of busy
//    iss_err   sticky flag: issue to an already-pending register
// ---------------------------------------------------------------------------
module regfile_sb #(
   parameter  int DW   = 16,
   parameter  int NREG = 8,
   parameter  int NRD  = 2,
   localparam int AW   = $clog2(NREG),
   localparam int CW   = $clog2(NREG + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*DW-1:0]   rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [DW-1:0]       wr_data,
   input  logic                iss_en,
   input  logic [AW-1:0]       iss_addr,
   input  logic                flush,
   output logic [NREG-1:0]     busy,
   output logic [CW-1:0]       n_busy,
   output logic                iss_err
);

   logic [DW-1:0]   r_mem [NREG];
   logic [NREG-1:0] r_busy;
   logic [CW-1:0]   r_nBusy;
   logic            r_issErr;

   logic [NREG-1:0] w_busyNext;
   logic [CW-1:0]   w_nBusyNext;
   logic            w_issErrNext;
   logic            w_wrAllowed;
   logic            w_issAllowed;
   logic            w_wrClearsIss;

   // Qualified write and issue strobes.  With the zero register enabled,
   // anything aimed at address 0 is dropped here, so storage, bypass and the
   // scoreboard all see register 0 as a constant that is never pending.
`ifdef REGFILE_SB_ZERO_REG_EN
   assign w_wrAllowed  = wr_en  && (wr_addr  != '0);
   assign w_issAllowed = iss_en && (iss_addr != '0);
`else
   assign w_wrAllowed  = wr_en;
   assign w_issAllowed = iss_en;
`endif

   // A writeback to the register being re-issued retires the old producer
   // in the same cycle, so that re-issue is legal and must not flag an error.
   assign w_wrClearsIss = w_wrAllowed && (wr_addr == iss_addr);

   // Register storage.  Flush has no effect here: a writeback in a flush
   // cycle still lands, because it belongs to an older, committed producer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wrAllowed) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   // Next-state scoreboard.  Per register the priority is flush, then issue,
   // then writeback; issue is applied after the write clear so that an issue
   // and a write to the same register leave it pending for the new producer.
   always_comb begin
      w_busyNext   = r_busy;
      w_issErrNext = r_issErr;
      if (flush) begin
         w_busyNext = '0;
      end else begin
         if (w_wrAllowed) begin
            w_busyNext[wr_addr] = 1'b0;
         end
         if (w_issAllowed) begin
            w_busyNext[iss_addr] = 1'b1;
            if (r_busy[iss_addr] && !w_wrClearsIss) begin
               w_issErrNext = 1'b1;
            end
         end
      end
   end

   // Population count of the next-state vector, so the registered count is
   // always consistent with the registered busy vector.
   always_comb begin
      w_nBusyNext = '0;
      for (int i = 0; i < NREG; i++) begin
         w_nBusyNext = w_nBusyNext + CW'(w_busyNext[i]);
      end
   end

   // Scoreboard state registers.  iss_err is sticky until reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_busy   <= '0;
         r_nBusy  <= '0;
         r_issErr <= 1'b0;
      end else begin
         r_busy   <= w_busyNext;
         r_nBusy  <= w_nBusyNext;
         r_issErr <= w_issErrNext;
      end
   end

   assign busy    = r_busy;
   assign n_busy  = r_nBusy;
   assign iss_err = r_issErr;

   // Read ports.  A same-cycle writeback to the addressed register is
   // forwarded and the operand is reported ready, since its value is now
   // on the write bus.  Otherwise storage and the pending bit are used.
   for (genvar p = 0; p < NRD; p++) begin : g_rdPort
      logic [AW-1:0] w_addr;
      logic          w_hit;

      assign w_addr = rd_addr[p*AW +: AW];
      assign w_hit  = w_wrAllowed && (wr_addr == w_addr);

      assign rd_data[p*DW +: DW] = w_hit ? wr_data : r_mem[w_addr];
      assign rd_busy[p]          = w_hit ? 1'b0    : r_busy[w_addr];
   end

endmodule

// File: tb/tb_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_sb
//
// Self-checking bench for regfile_sb with default parameters.  A stimulus
// process drives one cycle at a time, computes the expected outputs from a
// behavioural model of the register file and pushes them into a queue; a
// monitor pops and compares them against the DUT on every falling edge.
// ---------------------------------------------------------------------------
module tb_regfile_sb;

   localparam int DW   = 16;
   localparam int NREG = 8;
   localparam int NRD  = 2;
   localparam int AW   = 3;
   localparam int CW   = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [NRD*AW-1:0] rd_addr;
   logic [NRD*DW-1:0] rd_data;
   logic [NRD-1:0]    rd_busy;
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [DW-1:0]     wr_data;
   logic              iss_en;
   logic [AW-1:0]     iss_addr;
   logic              flush;
   logic [NREG-1:0]   busy;
   logic [CW-1:0]     n_busy;
   logic              iss_err;

   typedef struct {
      logic [NRD*DW-1:0] data;
      logic [NRD-1:0]    rbusy;
      logic [NREG-1:0]   busy;
      logic [CW-1:0]     nbusy;
      logic              err;
   } exp_t;

   exp_t expQ[$];
   exp_t monE;

   // Behavioural model state: register values, pending flags, sticky error.
   int mem   [NREG];
   bit pend  [NREG];
   bit errM;

   int testsRun    = 0;
   int testsFailed = 0;

   regfile_sb dut (
      .clk      (clk),
      .rst      (rst),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_busy  (rd_busy),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .flush    (flush),
      .busy     (busy),
      .n_busy   (n_busy),
      .iss_err  (iss_err)
   );

   // Free-running clock, 10 time-unit period.
   always #5 clk = ~clk;

   // One comparison: counts it, reports any difference.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
      testsRun++;
      if (act !== expv) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", name, act, expv, $time);
      end
   endtask

   // Monitor: on each falling edge, pop the expectation for this cycle and
   // compare every DUT output against it.
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         monE = expQ.pop_front();
         for (int p = 0; p < NRD; p++) begin
            checkOutput($sformatf("rd_data[%0d]", p), 64'(rd_data[p*DW +: DW]), 64'(monE.data[p*DW +: DW]));
            checkOutput($sformatf("rd_busy[%0d]", p), 64'(rd_busy[p]), 64'(monE.rbusy[p]));
         end
         checkOutput("busy",    64'(busy),    64'(monE.busy));
         checkOutput("n_busy",  64'(n_busy),  64'(monE.nbusy));
         checkOutput("iss_err", 64'(iss_err), 64'(monE.err));
      end
   end

   function automatic bit isZeroReg(input int a);
`ifdef REGFILE_SB_ZERO_REG_EN
      return (a == 0);
`else
      return 1'b0;
`endif
   endfunction

   // Drive one cycle of inputs, queue the expected outputs for this cycle,
   // then let the clock edge happen and advance the model.
   task automatic applyStimulus(input bit rstV, input bit wrEn, input int wa, input int wd,
                                input bit issEn, input int ia, input bit fl,
                                input int ra0, input int ra1);
      exp_t e;
      int   ra   [NRD];
      int   nmem [NREG];
      bit   npend[NREG];
      bit   nerr;
      bit   wrEff;
      bit   issEff;
      int   cnt;

      rst      = rstV;
      wr_en    = wrEn;
      wr_addr  = AW'(wa);
      wr_data  = DW'(wd);
      iss_en   = issEn;
      iss_addr = AW'(ia);
      flush    = fl;
      rd_addr  = {AW'(ra1), AW'(ra0)};

      // Asserting reset wipes everything at once.
      if (!rstV) begin
         for (int r = 0; r < NREG; r++) begin
            mem[r]  = 0;
            pend[r] = 1'b0;
         end
         errM = 1'b0;
      end

      wrEff  = wrEn  && !isZeroReg(wa);
      issEff = issEn && !isZeroReg(ia);

      ra[0] = ra0;
      ra[1] = ra1;
      for (int p = 0; p < NRD; p++) begin
         if (isZeroReg(ra[p])) begin
            e.data[p*DW +: DW] = '0;
            e.rbusy[p]         = 1'b0;
         end else if (wrEff && wa == ra[p]) begin
            e.data[p*DW +: DW] = DW'(wd);
            e.rbusy[p]         = 1'b0;
         end else begin
            e.data[p*DW +: DW] = DW'(mem[ra[p]]);
            e.rbusy[p]         = pend[ra[p]];
         end
      end
      cnt = 0;
      for (int r = 0; r < NREG; r++) begin
         e.busy[r] = pend[r];
         cnt += int'(pend[r]);
      end
      e.nbusy = CW'(cnt);
      e.err   = errM;
      expQ.push_back(e);

      // Model state after the edge, straight from the priority rules.
      nerr = errM;
      for (int r = 0; r < NREG; r++) begin
         nmem[r] = (wrEff && wa == r) ? wd : mem[r];
         if (fl)                      npend[r] = 1'b0;
         else if (issEff && ia == r)  npend[r] = 1'b1;
         else if (wrEff && wa == r)   npend[r] = 1'b0;
         else                         npend[r] = pend[r];
      end
      if (!fl && issEff && pend[ia] && !(wrEff && wa == ia)) begin
         nerr = 1'b1;
      end

      @(posedge clk);
      #1;
      if (rstV) begin
         for (int r = 0; r < NREG; r++) begin
            mem[r]  = nmem[r];
            pend[r] = npend[r];
         end
         errM = nerr;
      end
   endtask

   task automatic idle(input int ra0, input int ra1);
      applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0, ra0, ra1);
   endtask

   task automatic resetCycle();
      applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 0);
   endtask

   initial begin
      rst      = 1'b0;
      wr_en    = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      iss_en   = 1'b0;
      iss_addr = '0;
      flush    = 1'b0;
      rd_addr  = '0;
      for (int r = 0; r < NREG; r++) begin
         mem[r]  = 0;
         pend[r] = 1'b0;
      end
      errM = 1'b0;

      @(posedge clk);
      #1;
      resetCycle();
      resetCycle();

      // Every register reads zero on every port after reset.
      for (int r = 0; r < NREG; r++) begin
         idle(r, NREG - 1 - r);
      end

      // Bypass in the write cycle, storage on the next one.
      applyStimulus(1'b1, 1'b1, 3, 'hBEEF, 1'b0, 0, 1'b0, 3, 0);
      idle(3, 3);

      // Issue r5, observe it pending, then write it back.
      applyStimulus(1'b1, 1'b0, 0, 0, 1'b1, 5, 1'b0, 0, 0);
      idle(0, 5);
      applyStimulus(1'b1, 1'b1, 5, 'h0012, 1'b0, 0, 1'b0, 0, 5);
      idle(5, 5);

      // Double issue without writeback sets the sticky error.
      applyStimulus(1'b1, 1'b0, 0, 0, 1'b1, 2, 1'b0, 2, 2);
      applyStimulus(1'b1, 1'b0, 0, 0, 1'b1, 2, 1'b0, 2, 2);
      idle(2, 0);
      applyStimulus(1'b1, 1'b1, 2, 'h7777, 1'b0, 0, 1'b0, 2, 1);
      idle(2, 1);

      // Fresh start: issue and write r2 together keeps it pending, no error.
      resetCycle();
      applyStimulus(1'b1, 1'b0, 0, 0, 1'b1, 2, 1'b0, 2, 2);
      applyStimulus(1'b1, 1'b1, 2, 'hC0DE, 1'b1, 2, 1'b0, 2, 3);
      idle(2, 3);

      // Flush wins over a same-cycle issue.
      resetCycle();
      applyStimulus(1'b1, 1'b0, 0, 0, 1'b1, 1, 1'b0, 1, 4);
      applyStimulus(1'b1, 1'b0, 0, 0, 1'b1, 4, 1'b0, 1, 4);
      applyStimulus(1'b1, 1'b0, 0, 0, 1'b1, 6, 1'b0, 6, 7);
      applyStimulus(1'b1, 1'b1, 3, 'h3333, 1'b1, 7, 1'b1, 6, 7);
      idle(7, 3);

      // Reset in the middle of a write: storage clears at once, write lost.
      applyStimulus(1'b1, 1'b1, 4, 'h5555, 1'b0, 0, 1'b0, 0, 0);
      applyStimulus(1'b1, 1'b0, 0, 0, 1'b1, 1, 1'b0, 4, 1);
      applyStimulus(1'b0, 1'b1, 6, 'hAAAA, 1'b0, 0, 1'b0, 4, 6);
      idle(4, 6);

      // Register 0 behaviour depends on the build configuration.
      applyStimulus(1'b1, 1'b1, 0, 'h1234, 1'b0, 0, 1'b0, 0, 1);
      idle(0, 0);
      applyStimulus(1'b1, 1'b0, 0, 0, 1'b1, 0, 1'b0, 0, 0);
      idle(0, 0);
      applyStimulus(1'b1, 1'b0, 0, 0, 1'b1, 0, 1'b0, 0, 0);
      idle(0, 0);

      // Randomised traffic with occasional flush and reset.
      resetCycle();
      for (int n = 0; n < 400; n++) begin
         applyStimulus(($urandom % 64) != 0,
                       1'($urandom_range(0, 1)),
                       int'($urandom_range(0, NREG - 1)),
                       int'($urandom_range(0, 65535)),
                       ($urandom % 3) == 0,
                       int'($urandom_range(0, NREG - 1)),
                       ($urandom % 16) == 0,
                       int'($urandom_range(0, NREG - 1)),
                       int'($urandom_range(0, NREG - 1)));
      end

      repeat (2) @(negedge clk);
      #1;
      testsRun++;
      if (expQ.size() != 0) begin
         testsFailed++;
         $display("[TB] FAIL drain: got %0d queued expectations, expected 0", expQ.size());
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
